// File: rtl/axi4_pkg.sv
// axi4_pkg
// Shared AXI4 encodings and the burst writer's state type.
//   burst_e  : AXI4 AxBURST codes (FIXED, INCR, WRAP)
//   resp_e   : AXI4 xRESP codes (OKAY, EXOKAY, SLVERR, DECERR)
//   SIZE_8B  : AxSIZE code for 8-byte beats
//   BOUNDARY_4K : bursts must never cross a multiple of this many bytes
//   state_e  : burst writer FSM states
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [2:0] SIZE_8B     = 3'd3;
  localparam int         BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

endpackage

// File: rtl/axi4_burst_len_calc.sv
// axi4_burst_len_calc
// Combinational burst sizing: the number of 64-bit beats in the next burst is
// the smallest of the beats still to write, the configured maximum burst and
// the beats left before the next 4 KiB boundary.
//   i_remaining : beats still to write for the current command (nonzero when used)
//   i_wordIdx   : address bits [11:3], i.e. the 8-byte word index inside the 4 KiB page
//   o_len       : beats in the next burst (1..MAX_BURST)
module axi4_burst_len_calc
  import axi4_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [15:0] i_remaining,
  input  logic [8:0]  i_wordIdx,
  output logic [8:0]  o_len
);

  localparam int WORDS_4K = BOUNDARY_4K / 8;

  logic [9:0] w_toBoundary;
  logic [8:0] w_capped;

  // Words left in this page ranges 1..512, so it needs ten bits; the capped
  // count never exceeds 256, so when the page limit wins it fits in nine bits.
  assign w_toBoundary = 10'(WORDS_4K) - {1'b0, i_wordIdx};
  assign w_capped     = (i_remaining > 16'(MAX_BURST)) ? 9'(MAX_BURST) : i_remaining[8:0];
  assign o_len        = ({1'b0, w_capped} > w_toBoundary) ? w_toBoundary[8:0] : w_capped;

endmodule

// File: rtl/axi4_burst_writer.sv
// axi4_burst_writer
// AXI4 write initiator: accepts a start address and a beat count, then
// streams 64-bit words out as INCR bursts that never cross 4 KiB, one burst
// outstanding at a time.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_*             : command port (valid/ready, byte address, beat count)
//   s_*               : input data stream (valid/ready/data)
//   aw_*, w_*, b_*    : AXI4 write address, write data and write response channels
//   busy              : high whenever not idle
//   done              : one-cycle pulse when a command completes
//   err               : sticky error for the current command, valid with done
module axi4_burst_writer
  import axi4_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_beats,

  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,

  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ID_W-1:0]   aw_id,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic [2:0]        aw_size,
  output logic [1:0]        aw_burst,

  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [7:0]        w_strb,
  output logic              w_last,

  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ID_W-1:0]   b_id,
  input  logic [1:0]        b_resp,

  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            r_state;
  logic              r_cmdReady;
  logic              r_awValid;
  logic [7:0]        r_awLen;
  logic              r_bReady;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_remaining;
  logic [8:0]        r_beatCnt;

  logic [ADDR_W-1:0] w_calcAddr;
  logic [15:0]       w_calcRem;
  logic [8:0]        w_len;
  logic [7:0]        w_awLen;
  logic              w_inW;
  logic              w_wHs;

  // Bursts are sized when the FSM moves into AW, which happens either straight
  // from IDLE (the command is not latched yet, so size from the command port)
  // or from B (size from the already-advanced address and remaining count).
  assign w_calcAddr = (r_state == ST_IDLE) ? (cmd_addr & ~ADDR_W'(7)) : r_addr;
  assign w_calcRem  = (r_state == ST_IDLE) ? cmd_beats : r_remaining;

  axi4_burst_len_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_lenCalc (
    .i_remaining (w_calcRem),
    .i_wordIdx   (w_calcAddr[11:3]),
    .o_len       (w_len)
  );

  assign w_awLen = 8'(w_len - 9'd1);

  // The W channel is a direct pass-through of the stream while in W; the
  // stream source holds its data while stalled, which keeps W AXI-stable.
  assign w_inW  = (r_state == ST_W);
  assign w_wHs  = w_inW & s_valid & w_ready;

  assign s_ready  = w_inW & w_ready;
  assign w_valid  = w_inW & s_valid;
  assign w_data   = s_data;
  assign w_strb   = 8'hFF;
  assign w_last   = w_inW & (r_beatCnt == 9'd1);

  assign aw_valid = r_awValid;
  assign aw_addr  = r_addr;
  assign aw_len   = r_awLen;
  assign aw_size  = SIZE_8B;
  assign aw_burst = BURST_INCR;
  assign aw_id    = ID_W'(AXI_ID);

  assign b_ready   = r_bReady;
  assign cmd_ready = r_cmdReady;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

  // Command FSM. r_addr doubles as the AW address: it only moves on W beats,
  // so it is stable for the whole time aw_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmdReady  <= 1'b1;
      r_awValid   <= 1'b0;
      r_awLen     <= '0;
      r_bReady    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beatCnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmdReady  <= 1'b0;
            r_addr      <= w_calcAddr;
            r_remaining <= cmd_beats;
            r_err       <= 1'b0;
            if (cmd_beats == 16'd0) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_awValid <= 1'b1;
              r_awLen   <= w_awLen;
              r_state   <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (aw_ready) begin
            r_awValid <= 1'b0;
            r_beatCnt <= {1'b0, r_awLen} + 9'd1;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (w_wHs) begin
            r_beatCnt   <= r_beatCnt - 9'd1;
            r_remaining <= r_remaining - 16'd1;
            r_addr      <= r_addr + ADDR_W'(8);
            if (r_beatCnt == 9'd1) begin
              r_bReady <= 1'b1;
              r_state  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (b_valid) begin
            r_bReady <= 1'b0;
            // Errors are recorded but never abort the remaining bursts.
            if ((b_resp != RESP_OKAY) || (b_id != ID_W'(AXI_ID))) begin
              r_err <= 1'b1;
            end
            if (r_remaining != 16'd0) begin
              r_awValid <= 1'b1;
              r_awLen   <= w_awLen;
              r_state   <= ST_AW;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done     <= 1'b0;
          r_cmdReady <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_writer.sv
// tb_axi4_burst_writer
// Self-checking bench for axi4_burst_writer: a memory-backed AXI4 write
// responder with optional random stalls, a stream source with optional gaps,
// and a burst-splitting reference model computed from address arithmetic.
module tb_axi4_burst_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr  = '0;
  logic [15:0] cmd_beats = '0;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data  = '0;

  logic        aw_valid;
  logic        aw_ready = 1'b0;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;

  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;

  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [3:0]  b_id    = '0;
  logic [1:0]  b_resp  = '0;

  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  axi4_burst_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .aw_id     (aw_id),
    .aw_addr   (aw_addr),
    .aw_len    (aw_len),
    .aw_size   (aw_size),
    .aw_burst  (aw_burst),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .w_last    (w_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_id      (b_id),
    .b_resp    (b_resp),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  int nCompared   = 0;
  int nMismatched = 0;

  // Stimulus configuration, written only by the test sequence.
  bit          stallEn  = 0;
  bit          gapEn    = 0;
  int          errBurst = -1;
  logic [63:0] srcData[$];

  // Responder/monitor state, written only by the posedge monitor.
  logic [63:0] mem [bit [28:0]];
  burst_t      awLog[$];
  int          awCount   = 0;
  int          beatCount = 0;
  int          doneCount = 0;
  int          bCount    = 0;
  int          protoErr  = 0;
  int          srcIdx    = 0;
  logic        errAtDone = 1'b0;
  bit          sHs = 0, awSeen = 0, bPending = 0;
  bit          prevAwStall = 0, prevWStall = 0;
  logic [31:0] prevAwAddr = '0, curAddr = '0;
  logic [7:0]  prevAwLen  = '0;
  logic [63:0] prevWData  = '0;
  logic        prevWLast  = 1'b0;
  int          curLen = 0, wCnt = 0;

  // Per-command snapshot and expectations, written by runCommand.
  burst_t expBursts[$];
  int     startAw, startBeat, startDone, startProto, startSrc;
  bit     timedOut;

  // Responder and protocol monitor: samples every handshake on the rising
  // edge, stores written data, and counts any AXI rule it sees broken.
  always @(posedge clk) begin
    if (rst) begin
      awSeen      = 0;
      bPending    = 0;
      sHs         = 0;
      prevAwStall = 0;
      prevWStall  = 0;
    end else begin
      if (prevAwStall && (!aw_valid || aw_addr !== prevAwAddr || aw_len !== prevAwLen)) protoErr++;
      if (prevWStall && (!w_valid || w_data !== prevWData || w_last !== prevWLast)) protoErr++;
      prevAwStall = aw_valid && !aw_ready;
      prevAwAddr  = aw_addr;
      prevAwLen   = aw_len;
      prevWStall  = w_valid && !w_ready;
      prevWData   = w_data;
      prevWLast   = w_last;

      sHs = s_valid && s_ready;
      if (sHs) srcIdx++;

      if (w_valid && !awSeen) protoErr++;
      if (w_valid && w_ready && awSeen) begin
        mem[29'((curAddr >> 3) + 32'(wCnt))] = w_data;
        if (w_last !== (wCnt == curLen - 1)) protoErr++;
        if (w_strb !== 8'hFF) protoErr++;
        wCnt++;
        beatCount++;
        if (wCnt == curLen) begin
          awSeen   = 0;
          bPending = 1;
        end
      end

      if (aw_valid && aw_ready) begin
        if (aw_size !== 3'd3 || aw_burst !== 2'b01 || aw_id !== 4'd0 || awSeen || bPending) protoErr++;
        awLog.push_back('{aw_addr, int'(aw_len) + 1});
        awCount++;
        awSeen  = 1;
        curAddr = aw_addr;
        curLen  = int'(aw_len) + 1;
        wCnt    = 0;
      end

      if (b_valid && b_ready) begin
        bPending = 0;
        bCount++;
      end

      if (done) begin
        doneCount++;
        errAtDone = err;
      end
    end
  end

  // Responder handshake signals and the stream source change on the falling
  // edge; a presented stream word is held until it is taken.
  always @(negedge clk) begin
    aw_ready = stallEn ? ($urandom_range(0, 1) == 1) : 1'b1;
    w_ready  = stallEn ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!bPending) begin
      b_valid = 1'b0;
    end else if (!b_valid) begin
      b_valid = !stallEn || ($urandom_range(0, 1) == 1);
    end
    b_resp = (bCount == errBurst) ? 2'b10 : 2'b00;
    b_id   = 4'd0;
    if (!(s_valid && !sHs)) begin
      if (srcIdx < srcData.size() && (!gapEn || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_data  = srcData[srcIdx];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Reference model: split a command into bursts from the address rules alone,
  // queue its stream data, issue it and wait for completion.
  task automatic runCommand(input logic [31:0] addr, input int beats, input bit countUp);
    logic [31:0] a;
    int          rem, toB, l, t;
    startAw    = awCount;
    startBeat  = beatCount;
    startDone  = doneCount;
    startProto = protoErr;
    startSrc   = srcData.size();
    timedOut   = 0;
    expBursts.delete();
    a   = addr & 32'hFFFF_FFF8;
    rem = beats;
    while (rem > 0) begin
      toB = (4096 - int'(a % 4096)) / 8;
      l   = rem;
      if (l > 16)  l = 16;
      if (l > toB) l = toB;
      expBursts.push_back('{a, l});
      a   = a + 32'(l * 8);
      rem = rem - l;
    end
    for (int i = 0; i < beats; i++) begin
      srcData.push_back(countUp ? 64'(i + 1) : {$urandom, $urandom});
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_beats = 16'(beats);
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (t >= 200) timedOut = 1;
    t = 0;
    while (doneCount == startDone && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) timedOut = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({cmd_ready, busy, aw_valid, w_valid, s_ready, b_ready, done, err} !== 8'b1000_0000) begin
      nMismatched++;
      $display("[TB] FAIL reset_state got %b want 10000000",
               {cmd_ready, busy, aw_valid, w_valid, s_ready, b_ready, done, err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int bad;
    runCommand(32'h8000_0000, 4, 1);
    nCompared++;
    if (timedOut || awCount - startAw !== 1 || awLog[startAw].addr !== 32'h8000_0000 || awLog[startAw].len !== 4) begin
      nMismatched++;
      $display("[TB] FAIL single_aw got count=%0d timeout=%0d want one AW len=4 @80000000", awCount - startAw, timedOut);
    end
    nCompared++;
    if (beatCount - startBeat !== 4 || doneCount - startDone !== 1 || protoErr - startProto !== 0) begin
      nMismatched++;
      $display("[TB] FAIL single_counts got beats=%0d dones=%0d proto=%0d want 4/1/0",
               beatCount - startBeat, doneCount - startDone, protoErr - startProto);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!mem.exists(29'(32'h1000_0000 + 32'(i))) || mem[29'(32'h1000_0000 + 32'(i))] !== 64'(i + 1)) bad++;
    end
    nCompared++;
    if (bad !== 0 || errAtDone !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL single_mem got badWords=%0d err=%b want 0/0", bad, errAtDone);
    end
  endtask

  // Shared post-command check used by the multi-burst scenarios: compares the
  // observed bursts, beat total, done pulses, protocol errors, memory and err.
  task automatic checkCommand(input string name, input int beats, input logic expErr);
    int bad;
    nCompared++;
    if (timedOut || awCount - startAw !== expBursts.size()) begin
      nMismatched++;
      $display("[TB] FAIL %s_awcount got %0d timeout=%0d want %0d", name, awCount - startAw, timedOut, expBursts.size());
    end else begin
      bad = 0;
      for (int k = 0; k < expBursts.size(); k++) begin
        if (awLog[startAw + k].addr !== expBursts[k].addr || awLog[startAw + k].len !== expBursts[k].len) bad++;
      end
      nCompared++;
      if (bad !== 0) begin
        nMismatched++;
        $display("[TB] FAIL %s_awlist got %0d wrong bursts want 0", name, bad);
      end
    end
    nCompared++;
    if (beatCount - startBeat !== beats || doneCount - startDone !== 1 || protoErr - startProto !== 0) begin
      nMismatched++;
      $display("[TB] FAIL %s_counts got beats=%0d dones=%0d proto=%0d want %0d/1/0",
               name, beatCount - startBeat, doneCount - startDone, protoErr - startProto, beats);
    end
    bad = 0;
    for (int i = 0; i < beats; i++) begin
      if (!mem.exists(29'((cmd_addr >> 3) + 32'(i))) || mem[29'((cmd_addr >> 3) + 32'(i))] !== srcData[startSrc + i]) bad++;
    end
    nCompared++;
    if (bad !== 0 || errAtDone !== expErr) begin
      nMismatched++;
      $display("[TB] FAIL %s_mem got badWords=%0d err=%b want 0/%b", name, bad, errAtDone, expErr);
    end
  endtask

  task automatic test_multi_burst;
    runCommand(32'h8000_0000, 40, 0);
    checkCommand("multi", 40, 1'b0);
  endtask

  task automatic test_4k_boundary;
    runCommand(32'h8000_0FF0, 4, 0);
    checkCommand("boundary", 4, 1'b0);
  endtask

  task automatic test_stalls;
    stallEn = 1;
    gapEn   = 1;
    runCommand(32'h8000_0208, 33, 0);
    checkCommand("stalls", 33, 1'b0);
    for (int n = 0; n < 3; n++) begin
      runCommand(32'h8000_0000 + 32'($urandom_range(0, 32'h1_FFFF)), $urandom_range(1, 60), 0);
      checkCommand("random", int'(cmd_beats), 1'b0);
    end
    stallEn = 0;
    gapEn   = 0;
  endtask

  task automatic test_error;
    errBurst = bCount + 1;
    runCommand(32'h8000_0400, 40, 0);
    checkCommand("error", 40, 1'b1);
    errBurst = -1;
    runCommand(32'h8000_0800, 2, 0);
    checkCommand("after_error", 2, 1'b0);
  endtask

  task automatic test_zero_beats;
    int d0, a0, t;
    d0 = doneCount;
    a0 = awCount;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h8000_0100;
    cmd_beats = 16'd0;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    nCompared++;
    if ({done, busy, cmd_ready, aw_valid} !== 4'b1100) begin
      nMismatched++;
      $display("[TB] FAIL zero_done got done/busy/ready/awv=%b want 1100", {done, busy, cmd_ready, aw_valid});
    end
    @(negedge clk);
    nCompared++;
    if ({done, busy, cmd_ready} !== 3'b001) begin
      nMismatched++;
      $display("[TB] FAIL zero_idle got done/busy/ready=%b want 001", {done, busy, cmd_ready});
    end
    repeat (2) @(negedge clk);
    nCompared++;
    if (doneCount - d0 !== 1 || awCount - a0 !== 0) begin
      nMismatched++;
      $display("[TB] FAIL zero_counts got dones=%0d aws=%0d want 1/0", doneCount - d0, awCount - a0);
    end
  endtask

  task automatic test_reset_mid_w;
    int b0, t;
    stallEn = 1;
    b0 = beatCount;
    for (int i = 0; i < 20; i++) srcData.push_back({$urandom, $urandom});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h8000_2000;
    cmd_beats = 16'd20;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (beatCount - b0 < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    nCompared++;
    if (t >= 2000 || {aw_valid, w_valid, b_ready, done, cmd_ready, busy} !== 6'b000010) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_w got aw/w/b/done/ready/busy=%b timeout=%0d want 000010",
               {aw_valid, w_valid, b_ready, done, cmd_ready, busy}, t >= 2000);
    end
    rst = 1'b0;
    stallEn = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_burst();
    test_4k_boundary();
    test_stalls();
    test_error();
    test_zero_beats();
    test_reset_mid_w();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got no completion want finish before 90000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi4_burst_writer.md
Name: axi4_burst_writer

Overview:
- AXI4 write initiator: takes a start address and beat count on a command port, then a 64-bit data stream, and issues INCR write bursts to an AXI4 memory responder.
- Main use is loading program images into the 128 KiB system RAM at 0x8000_0000 before the CPU leaves reset, replacing the simulation-only file preload.
- Write channels only (AW/W/B); one burst outstanding at a time.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width; fixed at 64 (aw_size = 3).
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on aw_id and expected on b_id.
- MAX_BURST, 16, maximum beats per burst; legal range 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready; high only in IDLE.
- cmd_addr  in  ADDR_W  byte start address; bits [2:0] are ignored (forced to 0).
- cmd_beats  in  16  number of 64-bit words to write; 0 is legal.
- s_valid  in  1  data stream valid.
- s_ready  out  1  data stream ready.
- s_data  in  DATA_W  data word.
- aw_valid/aw_ready/aw_id/aw_addr/aw_len[7:0]/aw_size[2:0]/aw_burst[1:0]  out/in/out/out/out/out/out  AXI4 AW channel.
- w_valid/w_ready/w_data/w_strb[7:0]/w_last  out/in/out/out/out  AXI4 W channel.
- b_valid/b_ready/b_id/b_resp[1:0]  in/out/in/in  AXI4 B channel.
- busy  out  1  high whenever the block is not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky error for the current command; valid at done.

Behaviour:
- Reset values: all valid outputs 0, b_ready 0, done 0, err 0, busy 0, cmd_ready 1, state IDLE. Reset during any state reaches IDLE on the next edge and abandons any in-flight AXI transaction; the responder must be reset with it.
- FSM states: IDLE, AW, W, B, DONE.
- IDLE:
  - On cmd_valid & cmd_ready, latch addr (bits [2:0] cleared) and remaining = cmd_beats, and clear err.
  - If cmd_beats == 0, go to DONE; otherwise go to AW.
- AW:
  - Burst length: len = min(remaining, MAX_BURST, 512 - addr[11:3]), so no burst crosses a 4 KiB boundary.
  - aw_valid = 1; aw_addr = addr; aw_len = len-1; aw_size = 3; aw_burst = INCR (01); aw_id = AXI_ID.
  - All AW signals are registered and held stable until aw_ready.
  - On the handshake, load the beat counter with len and go to W.
- W:
  - W data is never presented before the AW handshake of its burst.
  - w_valid = s_valid; s_ready = w_ready; w_data = s_data; w_strb = 8'hFF.
  - w_last = 1 when the beat counter == 1.
  - Each W handshake decrements the beat counter and remaining, and adds 8 to addr.
  - The handshake on the last beat goes to B.
  - s_ready is 0 in every other state.
  - AXI stability: the pass-through is legal only because the data source holds s_data stable while s_valid & !s_ready. The bench checks this.
- B:
  - b_ready = 1.
  - On b_valid: if b_resp != 2'b00 or b_id != AXI_ID, set err.
  - Then go to AW if remaining > 0, else to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Errors do not abort the command; every burst is still issued.
- Simultaneous events: a new cmd_valid during busy is held off by cmd_ready = 0. cmd_ready returns to 1 the cycle after DONE.
- Arithmetic: remaining is 16 bits; addr adds are ADDR_W bits and wrap modulo 2^ADDR_W with no error.

Decomposition:
- Package axi4_pkg:
  - burst codes: FIXED = 00, INCR = 01, WRAP = 10.
  - resp codes: OKAY, EXOKAY, SLVERR, DECERR.
  - SIZE_8B = 3; BOUNDARY_4K = 4096.
  - FSM state enum.
- Sub-module axi4_burst_len_calc: combinational min(remaining, MAX_BURST, beats to 4 KiB boundary). Unit-tested alone.

Test Plan:
All scenarios use axi4_full_ram as the responder with a 0x8000_0000 address offset.
1. cmd_addr 0x8000_0000, beats 4, data 1..4 -> one AW with len=3, size=3, burst=01; w_last on the 4th beat; done pulses once; RAM words 0..3 = 1..4; err = 0.
2. cmd_addr 0x8000_0000, beats 40, MAX_BURST 16 -> three AWs: len 15 @ 0x8000_0000, len 15 @ 0x8000_0080, len 7 @ 0x8000_0100; exactly 40 W beats; RAM is correct.
3. cmd_addr 0x8000_0FF0, beats 4 -> two AWs: len 1 @ 0x8000_0FF0 and len 1 @ 0x8000_1000; no burst crosses 4 KiB.
4. Random s_valid gaps plus random w_ready/aw_ready stalls, beats 33 -> AW and W signals stable while valid & !ready; RAM contents match the stream; one done pulse.
5. Responder forced to b_resp = 2'b10 on the second burst of a 40-beat command -> all 3 bursts are still issued; err = 1 at done; next command accepted with err cleared to 0.
6. (a) beats 0 -> done one cycle after DONE entry, no aw_valid. (b) rst asserted mid-W -> next cycle all valids 0, cmd_ready 1, busy 0.
